dynamic_output_arb8: RTL and testbench

Round-robin, packet-locking arbiter that shares one dynamic-network output port among eight input requesters. Selects a winner, drives the 3-bit select of the downstream 8:1 flit mux, and holds that select for the full packet (header plus payload flits) so that wormhole packets are never interleaved. It sits in the dynamic node between the input FIFOs and the output crossbar mux, one instance per output direction.

---
 rtl/dynamic_output_arb8.sv | 105 ++++++++++
 tb/tb_dynamic_output_arb8.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_output_arb8.sv
// Round-robin, packet-locking 8:1 output arbiter; 1-cycle arbitration, select held for the whole wormhole packet.
// Header may transfer in the first SEND cycle; out_ready low or an owner bubble holds the lock without popping.
module dynamic_output_arb8 #(
   parameter int LEN_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         req,
   input  logic [8*LEN_W-1:0] len_in,
   input  logic               out_ready,
   output logic [2:0]         sel,
   output logic [7:0]         grant,
   output logic               valid_out,
   output logic [7:0]         pop,
   output logic               busy
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

   state_t         state, state_n;
   logic [2:0]     sel_n;
   logic [7:0]     grant_n;
   logic           busy_n;
   logic [LEN_W:0] remaining, remaining_n;
   logic [2:0]     last_ptr, last_ptr_n;

   logic [2:0]     winner;
   logic [2:0]     cand;
   logic           found;
   logic           xfer;

   // Search upward from the slot after the last winner; k = 8 wraps back onto last_ptr itself.
   always_comb begin
      found  = 1'b0;
      winner = last_ptr;
      cand   = last_ptr;
      for (int k = 1; k <= 8; k++) begin
         cand = last_ptr + 3'(k);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign xfer = (state == SEND) && req[sel] && out_ready;

   always_comb begin
      state_n     = state;
      sel_n       = sel;
      grant_n     = grant;
      busy_n      = busy;
      remaining_n = remaining;
      last_ptr_n  = last_ptr;
      valid_out   = 1'b0;
      pop         = 8'h00;
      case (state)
         IDLE: begin
            if (found) begin
               state_n     = SEND;
               sel_n       = winner;
               grant_n     = 8'h01 << winner;
               busy_n      = 1'b1;
               last_ptr_n  = winner;
               remaining_n = {1'b0, len_in[winner*LEN_W +: LEN_W]} + ONE;
            end
         end
         SEND: begin
            valid_out = req[sel];
            if (xfer) begin
               pop         = grant;
               remaining_n = remaining - ONE;
               // Last flit of the packet: drop the lock but leave sel where it is.
               if (remaining == ONE) begin
                  state_n = IDLE;
                  grant_n = 8'h00;
                  busy_n  = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sel       <= 3'd0;
         grant     <= 8'h00;
         busy      <= 1'b0;
         remaining <= '0;
         last_ptr  <= 3'd7;
      end else begin
         state     <= state_n;
         sel       <= sel_n;
         grant     <= grant_n;
         busy      <= busy_n;
         remaining <= remaining_n;
         last_ptr  <= last_ptr_n;
      end
   end

endmodule

// File: tb/tb_dynamic_output_arb8.sv
// Directed bench for dynamic_output_arb8: hand-computed grant/pop/busy sequences.
module tb_dynamic_output_arb8;

   localparam int LEN_W = 8;

   logic               clk;
   logic               reset;
   logic [7:0]         req;
   logic [8*LEN_W-1:0] len_in;
   logic               out_ready;
   logic [2:0]         sel;
   logic [7:0]         grant;
   logic               valid_out;
   logic [7:0]         pop;
   logic               busy;

   int n_assert = 0;
   int n_fail   = 0;

   dynamic_output_arb8 #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .len_in    (len_in),
      .out_ready (out_ready),
      .sel       (sel),
      .grant     (grant),
      .valid_out (valid_out),
      .pop       (pop),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance one edge, then let outputs settle before any checks.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int i, input logic [LEN_W-1:0] v);
      len_in[i*LEN_W +: LEN_W] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      req       = 8'h00;
      len_in    = '0;
      out_ready = 1'b0;
      do_reset();

      chk("rst_sel",   8'(sel),       8'h00);
      chk("rst_grant", grant,         8'h00);
      chk("rst_busy",  8'(busy),      8'h00);
      chk("rst_valid", 8'(valid_out), 8'h00);
      chk("rst_pop",   pop,           8'h00);

      // Single 3-flit packet from input 0
      req = 8'h01; set_len(0, 8'd2); out_ready = 1'b1; #1;
      chk("t1_idle_pop",   pop,           8'h00);
      chk("t1_idle_valid", 8'(valid_out), 8'h00);
      cyc();
      chk("t1_grant", grant,    8'h01);
      chk("t1_sel",   8'(sel),  8'h00);
      chk("t1_busy",  8'(busy), 8'h01);
      chk("t1_valid", 8'(valid_out), 8'h01);
      chk("t1_pop0",  pop,      8'h01);
      cyc();
      chk("t1_pop1",  pop,      8'h01);
      cyc();
      chk("t1_pop2",  pop,      8'h01);
      cyc();
      req = 8'h00; #1;
      chk("t1_done_busy",  8'(busy), 8'h00);
      chk("t1_done_grant", grant,    8'h00);
      chk("t1_done_pop",   pop,      8'h00);

      // All requesting, header-only packets: rotation 0..7,0 with one idle cycle between
      do_reset();
      len_in = '0; req = 8'hFF; out_ready = 1'b1; #1;
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk("t2_grant", grant,   8'h01 << (k % 8));
         chk("t2_sel",   8'(sel), 8'(k % 8));
         chk("t2_pop",   pop,     8'h01 << (k % 8));
         cyc();
         chk("t2_gap_busy", 8'(busy), 8'h00);
         chk("t2_gap_pop",  pop,      8'h00);
      end
      req = 8'h00;
      // last_ptr = 0 now

      // Owner 3, len 3, bubble of 2 cycles while input 5 requests
      req = 8'h08; set_len(3, 8'd3); set_len(5, 8'd0);
      cyc();
      chk("t3_grant",  grant, 8'h08);
      chk("t3_pop_a",  pop,   8'h08);
      cyc();
      chk("t3_pop_b",  pop,   8'h08);
      cyc();
      req = 8'h20; #1;
      chk("t3_bub_grant", grant,         8'h08);
      chk("t3_bub_pop",   pop,           8'h00);
      chk("t3_bub_valid", 8'(valid_out), 8'h00);
      cyc();
      chk("t3_bub2_grant", grant, 8'h08);
      chk("t3_bub2_pop",   pop,   8'h00);
      cyc();
      req = 8'h28; #1;
      chk("t3_pop_c", pop, 8'h08);
      cyc();
      chk("t3_pop_d",  pop,      8'h08);
      chk("t3_busy_d", 8'(busy), 8'h01);
      cyc();
      chk("t3_rel_busy", 8'(busy), 8'h00);
      chk("t3_rel_pop",  pop,      8'h00);
      cyc();
      chk("t3_next_grant", grant, 8'h20);
      cyc();
      req = 8'h00; #1;
      chk("t3_end_busy", 8'(busy), 8'h00);
      // last_ptr = 5

      // out_ready stall: input 1, len 1
      req = 8'h02; set_len(1, 8'd1); out_ready = 1'b0;
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("t4_stall_grant", grant,         8'h02);
         chk("t4_stall_valid", 8'(valid_out), 8'h01);
         chk("t4_stall_pop",   pop,           8'h00);
         cyc();
      end
      out_ready = 1'b1; #1;
      chk("t4_pop_a", pop, 8'h02);
      cyc();
      chk("t4_pop_b",  pop,      8'h02);
      chk("t4_busy_b", 8'(busy), 8'h01);
      cyc();
      req = 8'h00; #1;
      chk("t4_done_busy", 8'(busy), 8'h00);
      // last_ptr = 1

      // Wrap: move last_ptr to 6, then inputs 0 and 6 request
      req = 8'h40; set_len(6, 8'd0);
      cyc();
      chk("t5_pre_grant", grant, 8'h40);
      cyc();
      req = 8'h41; set_len(0, 8'd0); #1;
      chk("t5_pre_busy", 8'(busy), 8'h00);
      cyc();
      chk("t5_wrap_grant", grant, 8'h01);
      cyc();
      cyc();
      chk("t5_then_grant", grant, 8'h40);
      cyc();
      req = 8'h00; #1;
      // last_ptr = 6

      // Reset mid-packet: input 4, len 4, remaining 5 at the moment reset arrives
      req = 8'h10; set_len(4, 8'd4); out_ready = 1'b0;
      cyc();
      chk("t6_grant", grant,    8'h10);
      chk("t6_busy",  8'(busy), 8'h01);
      chk("t6_sel",   8'(sel),  8'h04);
      reset = 1'b1;
      cyc();
      out_ready = 1'b1; #1;
      chk("t6_rst_busy",  8'(busy), 8'h00);
      chk("t6_rst_grant", grant,    8'h00);
      chk("t6_rst_sel",   8'(sel),  8'h00);
      chk("t6_rst_pop",   pop,      8'h00);
      reset = 1'b0; req = 8'h11; set_len(0, 8'd0); #1;
      cyc();
      chk("t6_after_grant", grant, 8'h01);
      chk("t6_after_pop",   pop,   8'h01);
      req = 8'h00;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
